// File: rtl/dbf_line_seq_pkg.sv
// dbf_line_seq_pkg
//   Shared definitions for the DBF per-line sequencer:
//     seq_state_t    - sequencer state encoding (IDLE=0, TX=1, GUARD=2, RX=3, DONE=4)
//     DBF_ADDR_WD    - default LUT address width, shared with the channel blocks
//     ZONE_LEN_MIN   - value substituted for a zone_len of 0
//     cnt_width()    - width of a down-counter that must hold max(a,b,c)-1
package dbf_line_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TX    = 3'd1,
        ST_GUARD = 3'd2,
        ST_RX    = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    localparam int DBF_ADDR_WD  = 7;
    localparam int ZONE_LEN_MIN = 1;

    // Counters are loaded with (length - 1) and count down to 0, so the
    // widest value ever stored is max(a,b,c) - 1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dbf_line_seq_if.sv
// dbf_line_seq_if
//   Bundles the sequencer's request inputs, host LUT write port and the
//   shared channel control bus.
//     master : the sequencer (drives tx_en/start/dbf_lut_*, status pulses)
//     slave  : the controller/host side (drives line_go/abort/zone_len/host_*)
//   Optional: DBF_SEQ_AUTO_REARM_EN adds rearm_cnt (8 bits).
interface dbf_line_seq_if
    import dbf_line_seq_pkg::*;
#(
    parameter int ADDR_WD = DBF_ADDR_WD,
    parameter int ZL_WD   = 12
);
    logic               line_go;
    logic               abort;
    logic [ZL_WD-1:0]   zone_len;
    logic               host_we;
    logic [ADDR_WD-1:0] host_addr;
`ifdef DBF_SEQ_AUTO_REARM_EN
    logic [7:0]         rearm_cnt;
`endif
    logic               tx_en;
    logic               start;
    logic [ADDR_WD-1:0] dbf_lut_addr;
    logic               dbf_lut_we;
    logic               busy;
    logic               line_done;
    logic               host_wr_err;

`ifdef DBF_SEQ_AUTO_REARM_EN
    modport master (
        input  line_go, abort, zone_len, host_we, host_addr, rearm_cnt,
        output tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done, host_wr_err
    );
    modport slave (
        output line_go, abort, zone_len, host_we, host_addr, rearm_cnt,
        input  tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done, host_wr_err
    );
`else
    modport master (
        input  line_go, abort, zone_len, host_we, host_addr,
        output tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done, host_wr_err
    );
    modport slave (
        output line_go, abort, zone_len, host_we, host_addr,
        input  tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done, host_wr_err
    );
`endif

endinterface

// File: rtl/dbf_seq_cnt.sv
// dbf_seq_cnt
//   Loadable down-counter with terminal-count flag. Load wins over
//   decrement; the count saturates at 0.
//   Ports: clk, rst_n (sync, active-low), load, load_val[WD], dec,
//          tc (count is zero).
module dbf_seq_cnt #(
    parameter int WD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [WD-1:0] load_val,
    input  logic          dec,
    output logic          tc
);
    logic [WD-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - WD'(1);
        end
    end

    assign tc = (cnt_reg == '0);

endmodule

// File: rtl/dbf_line_seq.sv
// dbf_line_seq
//   Per-scan-line sequencer for the DBF channel array. Runs
//   TX (tx_en for TX_CYC) -> GUARD (GUARD_CYC dead cycles, skipped if 0) ->
//   RX (start high, LUT address stepping through NUM_ZONES zones of
//   zone_len cycles) -> DONE (line_done pulse) -> IDLE. While idle, the LUT
//   address/write-enable bus is handed to the host with one cycle latency.
//   Ports: clk, rst_n (sync, active-low), bus (dbf_line_seq_if.master):
//     in : line_go, abort, zone_len, host_we, host_addr [, rearm_cnt]
//     out: tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done, host_wr_err
//   Optional: DBF_SEQ_AUTO_REARM_EN - DONE re-enters TX until rearm_cnt+1
//   lines have fired.
module dbf_line_seq
    import dbf_line_seq_pkg::*;
#(
    parameter int ADDR_WD   = DBF_ADDR_WD,
    parameter int NUM_ZONES = 64,
    parameter int TX_CYC    = 16,
    parameter int GUARD_CYC = 8,
    parameter int ZL_WD     = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    dbf_line_seq_if.master  bus
);
    localparam int PH_WD = cnt_width(TX_CYC, GUARD_CYC, 2**ZL_WD);

    localparam logic [PH_WD-1:0]   TX_LOAD    = PH_WD'(TX_CYC - 1);
    localparam logic [PH_WD-1:0]   GUARD_LOAD = PH_WD'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam logic [ADDR_WD-1:0] ZONE_LOAD  = ADDR_WD'(NUM_ZONES - 1);

    seq_state_t         state_reg, state_next;
    logic [ZL_WD-1:0]   zl_reg, zl_next;
    logic [ADDR_WD-1:0] addr_reg, addr_next;
    logic               we_reg, we_next;
    logic               err_reg, err_next;
    logic               tx_en_reg, start_reg, busy_reg, done_reg;

    logic               phase_load, phase_dec, phase_tc;
    logic [PH_WD-1:0]   phase_val;
    logic               zone_load, zone_dec, zone_tc;
    logic [ZL_WD-1:0]   zl_m1;
    logic [PH_WD-1:0]   rx_load;

`ifdef DBF_SEQ_AUTO_REARM_EN
    logic [7:0]         rearm_reg, rearm_next;
`endif

    // Phase counter: TX length, guard length, then cycles within a zone.
    dbf_seq_cnt #(.WD(PH_WD)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (phase_load),
        .load_val (phase_val),
        .dec      (phase_dec),
        .tc       (phase_tc)
    );

    // Zone counter: zones remaining after the current one.
    dbf_seq_cnt #(.WD(ADDR_WD)) u_zone_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (zone_load),
        .load_val (ZONE_LOAD),
        .dec      (zone_dec),
        .tc       (zone_tc)
    );

    assign zl_m1   = zl_reg - ZL_WD'(1);
    assign rx_load = PH_WD'(zl_m1);

    always_comb begin
        state_next = state_reg;
        zl_next    = zl_reg;
        addr_next  = addr_reg;
        we_next    = 1'b0;
        phase_load = 1'b0;
        phase_val  = TX_LOAD;
        phase_dec  = 1'b0;
        zone_load  = 1'b0;
        zone_dec   = 1'b0;
`ifdef DBF_SEQ_AUTO_REARM_EN
        rearm_next = rearm_reg;
`endif
        // A host write is refused whenever the bus is owned by the sequencer,
        // including the cycle in which a line is accepted.
        err_next = bus.host_we &&
                   ((state_reg != ST_IDLE) || (bus.line_go && !bus.abort));

        if (bus.abort) begin
            state_next = ST_IDLE;
            addr_next  = '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (bus.line_go) begin
                        state_next = ST_TX;
                        zl_next    = (bus.zone_len == '0) ? ZL_WD'(ZONE_LEN_MIN)
                                                          : bus.zone_len;
                        phase_load = 1'b1;
                        phase_val  = TX_LOAD;
                        zone_load  = 1'b1;
                        // Park the channel address at zone 0 for the whole line.
                        addr_next  = '0;
`ifdef DBF_SEQ_AUTO_REARM_EN
                        rearm_next = bus.rearm_cnt;
`endif
                    end else begin
                        addr_next = bus.host_addr;
                        we_next   = bus.host_we;
                    end
                end
                ST_TX: begin
                    if (!phase_tc) begin
                        phase_dec = 1'b1;
                    end else if (GUARD_CYC > 0) begin
                        state_next = ST_GUARD;
                        phase_load = 1'b1;
                        phase_val  = GUARD_LOAD;
                    end else begin
                        state_next = ST_RX;
                        phase_load = 1'b1;
                        phase_val  = rx_load;
                        addr_next  = '0;
                    end
                end
                ST_GUARD: begin
                    if (!phase_tc) begin
                        phase_dec = 1'b1;
                    end else begin
                        state_next = ST_RX;
                        phase_load = 1'b1;
                        phase_val  = rx_load;
                        addr_next  = '0;
                    end
                end
                ST_RX: begin
                    if (!phase_tc) begin
                        phase_dec = 1'b1;
                    end else if (zone_tc) begin
                        state_next = ST_DONE;
                        addr_next  = '0;
                    end else begin
                        zone_dec   = 1'b1;
                        phase_load = 1'b1;
                        phase_val  = rx_load;
                        addr_next  = addr_reg + ADDR_WD'(1);
                    end
                end
                ST_DONE: begin
`ifdef DBF_SEQ_AUTO_REARM_EN
                    if (rearm_reg != 8'd0) begin
                        state_next = ST_TX;
                        rearm_next = rearm_reg - 8'd1;
                        phase_load = 1'b1;
                        phase_val  = TX_LOAD;
                        zone_load  = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
`else
                    state_next = ST_IDLE;
`endif
                end
                default: begin
                    state_next = ST_IDLE;
                    addr_next  = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so that they line up with
    // state_reg in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            zl_reg    <= '0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            tx_en_reg <= 1'b0;
            start_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            zl_reg    <= zl_next;
            addr_reg  <= addr_next;
            we_reg    <= we_next;
            err_reg   <= err_next;
            tx_en_reg <= (state_next == ST_TX);
            start_reg <= (state_next == ST_RX);
            busy_reg  <= (state_next != ST_IDLE);
            done_reg  <= (state_next == ST_DONE);
        end
    end

`ifdef DBF_SEQ_AUTO_REARM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rearm_reg <= 8'd0;
        end else begin
            rearm_reg <= rearm_next;
        end
    end
`endif

    assign bus.tx_en        = tx_en_reg;
    assign bus.start        = start_reg;
    assign bus.dbf_lut_addr = addr_reg;
    assign bus.dbf_lut_we   = we_reg;
    assign bus.busy         = busy_reg;
    assign bus.line_done    = done_reg;
    assign bus.host_wr_err  = err_reg;

endmodule

// File: tb/tb_dbf_line_seq.sv
// tb_dbf_line_seq
//   Directed bench for dbf_line_seq with NUM_ZONES=4, TX_CYC=16, GUARD_CYC=8.
//   Idle host-path vectors come from a table; full lines, zone_len=0, abort,
//   mid-line reset and (with DBF_SEQ_AUTO_REARM_EN) auto-rearm are
//   hand-written sequences checked against a cycle-offset line timeline.
module tb_dbf_line_seq;

    localparam int AW  = 7;
    localparam int NZ  = 4;
    localparam int TXC = 16;
    localparam int GC  = 8;
    localparam int ZW  = 12;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dbf_line_seq_if #(.ADDR_WD(AW), .ZL_WD(ZW)) bus ();

    dbf_line_seq #(
        .ADDR_WD   (AW),
        .NUM_ZONES (NZ),
        .TX_CYC    (TXC),
        .GUARD_CYC (GC),
        .ZL_WD     (ZW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Observed outputs packed as {tx_en, start, we, busy, line_done, wr_err, addr}.
    logic [12:0] act;
    assign act = {bus.tx_en, bus.start, bus.dbf_lut_we, bus.busy,
                  bus.line_done, bus.host_wr_err, bus.dbf_lut_addr};

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        string       name;
        logic        lg;
        logic        ab;
        logic        hw;
        logic [6:0]  ha;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [12:0] pk(input logic tx, input logic st, input logic we,
                                       input logic bz, input logic dn, input logic er,
                                       input logic [6:0] ad);
        return {tx, st, we, bz, dn, er, ad};
    endfunction

    // Expected outputs k cycles after a line_go (k=1 is the first TX cycle)
    // for a line whose effective zone length is z. hw/ha are the host inputs
    // applied just before that cycle's edge.
    function automatic logic [12:0] line_exp(input int k, input int z,
                                             input logic hw, input logic [6:0] ha);
        int   rx_s, rx_e, dn, id0;
        logic er;
        rx_s = TXC + GC + 1;
        rx_e = TXC + GC + NZ * z;
        dn   = rx_e + 1;
        id0  = dn + 1;
        er   = hw && (k <= id0);
        if (k <= TXC)       return pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, er, 7'd0);
        else if (k < rx_s)  return pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, er, 7'd0);
        else if (k <= rx_e) return pk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, er, 7'((k - rx_s) / z));
        else if (k == dn)   return pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, er, 7'd0);
        else if (k == id0)  return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, er, 7'd0);
        else                return pk(1'b0, 1'b0, hw,   1'b0, 1'b0, er, ha);
    endfunction

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] a;
        a = act;
        vec_cnt++;
        if (a !== exp) begin
            err_cnt++;
            $display("FAIL %s: got tx=%b st=%b we=%b busy=%b done=%b err=%b addr=%0d, want tx=%b st=%b we=%b busy=%b done=%b err=%b addr=%0d",
                     name, a[12], a[11], a[10], a[9], a[8], a[7], a[6:0],
                     exp[12], exp[11], exp[10], exp[9], exp[8], exp[7], exp[6:0]);
        end else begin
            $display("ok   %s: tx=%b st=%b we=%b busy=%b done=%b err=%b addr=%0d",
                     name, a[12], a[11], a[10], a[9], a[8], a[7], a[6:0]);
        end
    endtask

    task automatic drive(input logic lg, input logic ab, input logic hw,
                         input logic [6:0] ha, input logic [11:0] zl);
        bus.line_go   = lg;
        bus.abort     = ab;
        bus.host_we   = hw;
        bus.host_addr = ha;
        bus.zone_len  = zl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       hw;
        logic [6:0] ha;

        tbl[0] = '{"idle_wr_5",        1'b0, 1'b0, 1'b1, 7'd5,   pk(0,0,1,0,0,0,7'd5)};
        tbl[1] = '{"idle_nowr_9",      1'b0, 1'b0, 1'b0, 7'd9,   pk(0,0,0,0,0,0,7'd9)};
        tbl[2] = '{"idle_wr_127",      1'b0, 1'b0, 1'b1, 7'd127, pk(0,0,1,0,0,0,7'd127)};
        tbl[3] = '{"idle_abort_wr",    1'b0, 1'b1, 1'b1, 7'd3,   pk(0,0,0,0,0,0,7'd0)};
        tbl[4] = '{"abort_plus_go",    1'b1, 1'b1, 1'b0, 7'd3,   pk(0,0,0,0,0,0,7'd0)};
        tbl[5] = '{"still_idle_6",     1'b0, 1'b0, 1'b0, 7'd6,   pk(0,0,0,0,0,0,7'd6)};

        rst_n = 1'b0;
`ifdef DBF_SEQ_AUTO_REARM_EN
        bus.rearm_cnt = 8'd0;
`endif
        drive(1'b1, 1'b0, 1'b1, 7'd33, 12'd3);
        repeat (3) tick();
        check("reset", pk(0,0,0,0,0,0,7'd0));
        rst_n = 1'b1;

        // Idle host path and same-cycle abort/line_go priority.
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].lg, tbl[i].ab, tbl[i].hw, tbl[i].ha, 12'd3);
            tick();
            check(tbl[i].name, tbl[i].exp);
        end

        // Line with zone_len=3; host write collides with line_go, a second
        // line_go lands in TX, another host write lands in RX.
        for (int k = 1; k <= 40; k++) begin
            hw = (k == 1) || (k == 29);
            ha = (k == 29) ? 7'd99 : 7'd17;
            drive((k == 1) || (k == 6), 1'b0, hw, ha, (k == 1) ? 12'd3 : 12'd7);
            tick();
            check($sformatf("lineA k=%0d", k), line_exp(k, 3, hw, ha));
        end

        // zone_len=0 behaves as 1: RX is NUM_ZONES cycles.
        for (int k = 1; k <= 32; k++) begin
            drive(k == 1, 1'b0, 1'b0, 7'd17, 12'd0);
            tick();
            check($sformatf("zl0 k=%0d", k), line_exp(k, 1, 1'b0, 7'd17));
        end

        // Abort while zone 2 is on the bus (zone 2 spans k=31..33), with a
        // simultaneous line_go that must be ignored.
        for (int k = 1; k <= 38; k++) begin
            drive((k == 1) || (k == 32), k == 32, 1'b0, 7'd17, 12'd3);
            tick();
            if (k < 32)       check($sformatf("abort k=%0d", k), line_exp(k, 3, 1'b0, 7'd17));
            else if (k == 32) check($sformatf("abort k=%0d", k), pk(0,0,0,0,0,0,7'd0));
            else              check($sformatf("abort k=%0d", k), pk(0,0,0,0,0,0,7'd17));
        end

        // Reset in the middle of TX.
        for (int k = 1; k <= 12; k++) begin
            rst_n = (k != 10);
            drive(k == 1, 1'b0, 1'b0, 7'd17, 12'd3);
            tick();
            if (k < 10)       check($sformatf("midrst k=%0d", k), line_exp(k, 3, 1'b0, 7'd17));
            else if (k == 10) check($sformatf("midrst k=%0d", k), pk(0,0,0,0,0,0,7'd0));
            else              check($sformatf("midrst k=%0d", k), pk(0,0,0,0,0,0,7'd17));
        end
        rst_n = 1'b1;

`ifdef DBF_SEQ_AUTO_REARM_EN
        // rearm_cnt=2, zone_len=1: three back-to-back 29-cycle lines.
        begin
            int per;
            int kk;
            per = TXC + GC + NZ + 1;
            for (int k = 1; k <= 3 * per + 3; k++) begin
                bus.rearm_cnt = (k == 1) ? 8'd2 : 8'd0;
                drive(k == 1, 1'b0, 1'b0, 7'd17, 12'd1);
                tick();
                kk = (k <= 3 * per) ? ((k - 1) % per) + 1 : k - 2 * per;
                check($sformatf("rearm k=%0d", k), line_exp(kk, 1, 1'b0, 7'd17));
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dbf_line_seq.md
Name: dbf_line_seq

Overview:
- Per-scan-line sequencer for the DBF channel array.
- Drives the shared control bus (tx_en, start, dbf_lut_addr, dbf_lut_we) that fans out to every dbf_chNN instance.
- Steps through transmit, guard, then a receive window in which the coarse/fine delay LUT address advances one focal zone at a time.
- Arbitrates the LUT address/write-enable bus between host LUT writes (idle only) and its own zone stepping.

Parameters:
- ADDR_WD, 7: LUT address width; must match the channel blocks.
- NUM_ZONES, 64: focal zones per line; must satisfy 1 <= NUM_ZONES <= 2^ADDR_WD.
- TX_CYC, 16: clk cycles tx_en is held high.
- GUARD_CYC, 8: dead cycles between end of transmit and receive start; 0 is legal.
- ZL_WD, 12: width of the zone-length input.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- line_go  in  1  single-cycle request to fire one line; honoured only in IDLE
- abort  in  1  force return to IDLE from any state
- zone_len  in  ZL_WD  samples per zone; sampled on line_go accept; 0 is treated as 1
- host_we  in  1  host LUT write strobe
- host_addr  in  ADDR_WD  host LUT write address
- tx_en  out  1  transmit window to channels
- start  out  1  receive/beamform enable to channels
- dbf_lut_addr  out  ADDR_WD  LUT address bus to channels
- dbf_lut_we  out  1  LUT write enable to channels
- busy  out  1  high in any state except IDLE
- line_done  out  1  one-cycle pulse at the end of a completed line
- host_wr_err  out  1  one-cycle pulse when host_we arrives while busy

Behaviour:
- All outputs are registered. On rst_n=0 at a clk edge, every output is 0 and the state is IDLE.
- States: IDLE, TX, GUARD, RX, DONE.
- IDLE:
  - dbf_lut_addr <= host_addr and dbf_lut_we <= host_we, one-cycle latency.
  - On line_go: latch zone_len (0 is mapped to 1), go to TX, clear the cycle and zone counters, dbf_lut_we <= 0.
  - If host_we and line_go arrive together, line_go wins: the write is dropped and host_wr_err pulses.
- TX:
  - tx_en=1 for exactly TX_CYC cycles, then go to GUARD.
  - If GUARD_CYC=0, go directly to RX.
- GUARD:
  - tx_en=0, start=0 for GUARD_CYC cycles, then go to RX.
- RX:
  - start=1 and dbf_lut_addr=zone index, starting at 0.
  - Each zone lasts the latched zone_len cycles; the address then increments.
  - After the last cycle of zone NUM_ZONES-1, go to DONE.
  - Total RX length is NUM_ZONES*zone_len cycles.
- DONE:
  - One cycle: start=0, line_done=1, dbf_lut_addr=0. Then go to IDLE.
- busy, tx_en and start are mutually consistent with the state in the same cycle; tx_en and start are never high together.
- line_go outside IDLE is ignored, with no queueing.
- host_we outside IDLE is ignored; host_wr_err pulses and dbf_lut_we stays 0.
- abort:
  - Takes effect next cycle from any state. The state goes to IDLE and tx_en, start and dbf_lut_we clear.
  - dbf_lut_addr becomes 0, then follows host_addr from the next cycle.
  - No line_done is generated.
  - abort has priority over line_go in the same cycle.
- Reset mid-line behaves as abort, but all outputs are 0.
- Counters are sized so they do not wrap: the cycle counter to max(TX_CYC, GUARD_CYC, 2^ZL_WD), the zone counter to ADDR_WD.

Optional Feature:
- Macro DBF_SEQ_AUTO_REARM_EN.
- Defined:
  - Adds input rearm_cnt (8 bits), sampled on line_go.
  - DONE returns to TX instead of IDLE until rearm_cnt+1 lines have fired; line_done pulses once per line.
  - busy stays high between lines; abort still terminates immediately.
- Undefined:
  - One line per line_go.
  - The port is absent and the logic is not synthesised.

Decomposition:
- Shared package/header (alongside param.h):
  - State encoding constants: IDLE=0, TX=1, GUARD=2, RX=3, DONE=4.
  - ADDR_WD default.
  - The zone_len zero-clamp constant.
- One sub-module is natural: dbf_seq_cnt, a loadable down-counter with a terminal-count flag.
  - Instantiated twice: once for phase cycles (TX/GUARD/zone length), once for the zone index.

Test Plan:
- Reset then idle host write: host_we=1, host_addr=5 -> next cycle dbf_lut_we=1, dbf_lut_addr=5; busy=0.
- Line with NUM_ZONES=4, zone_len=3, TX_CYC=16, GUARD_CYC=8, line_go at cycle t:
  - tx_en high t+1..t+16.
  - start high t+25..t+36, with addr 0,1,2,3 each held 3 cycles.
  - line_done at t+37; busy falls at t+38.
- zone_len=0 -> each zone lasts 1 cycle; RX lasts NUM_ZONES cycles.
- host_we during RX -> host_wr_err pulse, dbf_lut_we stays 0, zone addr unaffected. line_go during TX -> ignored; exactly one line_done.
- abort in RX at zone 2 -> next cycle start=0, busy=0, no line_done. Same-cycle abort+line_go in IDLE -> stays IDLE.
- DBF_SEQ_AUTO_REARM_EN, rearm_cnt=2 -> three line_done pulses, busy continuous, tx_en bursts separated by a full RX window.
